// File: rtl/sum_entry_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sum_entry_controller
//  Description : Key-entry sequencer for a two-operand decimal adder. Builds
//                operands A and B (up to MAX_DIGITS decimal digits each) from
//                keypad events, launches the adder with a one-cycle
//                start_suma pulse, then captures and holds the sum for the
//                display path.
//                Optional feature macro: SUM_CTRL_TIMEOUT_EN (WAIT timeout
//                with sticky error flag; when undefined, error is tied to 0).
//  Revision    : 1.0  initial release
// ============================================================================
module sum_entry_controller #(
    parameter int MAX_DIGITS     = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [11:0] number1,
    output logic [11:0] number2,
    output logic        start_suma,
    input  logic [13:0] sum,
    input  logic        valid,
    output logic [13:0] result,
    output logic        result_valid,
    output logic [11:0] entry_value,
    output logic        busy,
    output logic [2:0]  state,
    output logic        error
);

    // FSM encoding
    localparam logic [2:0] c_ENTER_A = 3'd0;
    localparam logic [2:0] c_ENTER_B = 3'd1;
    localparam logic [2:0] c_START   = 3'd2;
    localparam logic [2:0] c_WAIT    = 3'd3;
    localparam logic [2:0] c_SHOW    = 3'd4;

    localparam logic [3:0] c_KEY_ENTER = 4'hA;
    localparam logic [3:0] c_KEY_CLEAR = 4'hB;

    localparam int                 c_CNT_W   = $clog2(MAX_DIGITS + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_DIGITS);
    localparam logic [c_CNT_W-1:0] c_ONE_CNT = c_CNT_W'(1);

    // Reject illegal configurations at elaboration
    if ((MAX_DIGITS < 1) || (MAX_DIGITS > 3) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("sum_entry_controller: illegal MAX_DIGITS or TIMEOUT_CYCLES");
    end

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [11:0]        r_num1;
    logic [11:0]        r_num2;
    logic [13:0]        r_result;
    logic [11:0]        r_entry;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_wait_first;

    logic [11:0]        w_num1_next;
    logic [11:0]        w_num2_next;
    logic [13:0]        w_result_next;
    logic [11:0]        w_entry_next;
    logic [c_CNT_W-1:0] w_cnt_next;

    logic               w_is_digit;
    logic               w_is_enter;
    logic               w_is_clear;
    logic [11:0]        w_digit;
    logic               w_cnt_ok;
    logic               w_capture;
    logic               w_timeout;

    // Shift one decimal digit into an operand (bounded to 999 by the digit count)
    function automatic logic [11:0] f_push_digit(input logic [11:0] val, input logic [11:0] dig);
        f_push_digit = {val[8:0], 3'b000} + {val[10:0], 1'b0} + dig;
    endfunction

    assign w_is_digit = key_valid && (key_code <= 4'd9);
    assign w_is_enter = key_valid && (key_code == c_KEY_ENTER);
    assign w_is_clear = key_valid && (key_code == c_KEY_CLEAR);
    assign w_digit    = {8'd0, key_code};
    assign w_cnt_ok   = (r_cnt < c_MAX_CNT);
    // The first WAIT cycle may still see the previous operation's valid
    assign w_capture  = (r_state == c_WAIT) && !r_wait_first && valid;

`ifdef SUM_CTRL_TIMEOUT_EN
    localparam int                 c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               r_error;

    // Count cycles spent in WAIT; restarts on every new operation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo_cnt <= '0;
        end else if (r_state != c_WAIT) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
        end
    end

    assign w_timeout = (r_state == c_WAIT) && !w_capture && !w_is_clear &&
                       (r_tmo_cnt == c_TMO_LAST);

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_error <= 1'b0;
        end else if (w_timeout) begin
            r_error <= 1'b1;
        end
    end

    assign error = r_error;
`else
    assign w_timeout = 1'b0;
    assign error     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ENTER_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; CLEAR overrides everything
    always_comb begin
        w_state_next = r_state;
        if (w_is_clear) begin
            w_state_next = c_ENTER_A;
        end else begin
            case (r_state)
                c_ENTER_A: if (w_is_enter) w_state_next = c_ENTER_B;
                c_ENTER_B: if (w_is_enter) w_state_next = c_START;
                c_START:   w_state_next = c_WAIT;
                c_WAIT:    if (w_capture || w_timeout) w_state_next = c_SHOW;
                c_SHOW:    if (w_is_digit) w_state_next = c_ENTER_A;
                default:   w_state_next = c_ENTER_A;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        start_suma   = (r_state == c_START);
        busy         = (r_state == c_START) || (r_state == c_WAIT);
        result_valid = (r_state == c_SHOW);
    end

    // Datapath next values: operands, digit count, captured result, display mirror
    always_comb begin
        w_num1_next   = r_num1;
        w_num2_next   = r_num2;
        w_cnt_next    = r_cnt;
        w_result_next = r_result;
        if (w_is_clear) begin
            w_num1_next   = '0;
            w_num2_next   = '0;
            w_cnt_next    = '0;
            w_result_next = '0;
        end else begin
            case (r_state)
                c_ENTER_A: begin
                    if (w_is_digit && w_cnt_ok) begin
                        w_num1_next = f_push_digit(r_num1, w_digit);
                        w_cnt_next  = r_cnt + c_ONE_CNT;
                    end else if (w_is_enter) begin
                        w_cnt_next  = '0;
                    end
                end
                c_ENTER_B: begin
                    if (w_is_digit && w_cnt_ok) begin
                        w_num2_next = f_push_digit(r_num2, w_digit);
                        w_cnt_next  = r_cnt + c_ONE_CNT;
                    end else if (w_is_enter) begin
                        w_cnt_next  = '0;
                    end
                end
                c_WAIT: begin
                    if (w_capture) begin
                        w_result_next = sum;
                    end else if (w_timeout) begin
                        w_result_next = '0;
                    end
                end
                c_SHOW: begin
                    // A digit starts a fresh operation with this digit as A's first
                    if (w_is_digit) begin
                        w_num1_next = w_digit;
                        w_num2_next = '0;
                        w_cnt_next  = c_ONE_CNT;
                    end
                end
                default: ;
            endcase
        end
        // Display tracks the operand being typed and freezes otherwise
        if (w_state_next == c_ENTER_A) begin
            w_entry_next = w_num1_next;
        end else if (w_state_next == c_ENTER_B) begin
            w_entry_next = w_num2_next;
        end else begin
            w_entry_next = r_entry;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_num1       <= '0;
            r_num2       <= '0;
            r_cnt        <= '0;
            r_result     <= '0;
            r_entry      <= '0;
            r_wait_first <= 1'b0;
        end else begin
            r_num1       <= w_num1_next;
            r_num2       <= w_num2_next;
            r_cnt        <= w_cnt_next;
            r_result     <= w_result_next;
            r_entry      <= w_entry_next;
            r_wait_first <= (r_state == c_START);
        end
    end

    assign number1     = r_num1;
    assign number2     = r_num2;
    assign result      = r_result;
    assign entry_value = r_entry;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sum_entry_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sum_entry_controller
//  Description : Scoreboard bench for sum_entry_controller. Stimulus pushes
//                hand-computed sums; a monitor pops and compares on each
//                entry into SHOW. A small adder model answers start_suma,
//                keeping the previous valid asserted through the first WAIT
//                cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sum_entry_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic [11:0] number1;
    logic [11:0] number2;
    logic        start_suma;
    logic [13:0] sum = '0;
    logic        valid = 1'b0;
    logic [13:0] result;
    logic        result_valid;
    logic [11:0] entry_value;
    logic        busy;
    logic [2:0]  state;
    logic        error;

    int n_checks = 0;
    int n_errors = 0;
    int n_start  = 0;
    logic [13:0] exp_q[$];

    sum_entry_controller #(.MAX_DIGITS(3), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .number1(number1), .number2(number2), .start_suma(start_suma),
        .sum(sum), .valid(valid), .result(result), .result_valid(result_valid),
        .entry_value(entry_value), .busy(busy), .state(state), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One key strobe, issued and released on falling edges
    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic wait_show(input string name);
        int n;
        n = 0;
        while (state != 3'd4 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({name, "_reached_show"}, int'(state == 3'd4), 1);
    endtask

    // Adder model: stale valid persists through the first WAIT cycle
    initial begin
        logic [13:0] a;
        forever begin
            @(negedge clk);
            if (reset && start_suma) begin
                a = 14'(number1) + 14'(number2);
                @(negedge clk);
                @(negedge clk);
                valid = 1'b0;
                sum   = '0;
                @(negedge clk);
                sum   = a;
                valid = 1'b1;
            end
        end
    end

    // Monitor: compare captured result on each entry into SHOW, count launches
    initial begin
        logic prev_rv;
        logic [13:0] e;
        prev_rv = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && result_valid && !prev_rv) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", int'(result), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("result", int'(result), int'(e));
                end
            end
            prev_rv = result_valid;
            if (reset && start_suma) n_start++;
        end
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_state", int'(state), 0);
        check("rst_numbers", int'({number1, number2}), 0);
        check("rst_result", int'(result), 0);
        check("rst_flags", int'({start_suma, result_valid, busy, error}), 0);
        check("rst_entry", int'(entry_value), 0);
        reset = 1'b1;
        @(negedge clk);

        // 123 + 456
        press(4'd1); press(4'd2); press(4'd3);
        check("a_123", int'(number1), 123);
        check("entry_123", int'(entry_value), 123);
        press(4'hA);
        check("state_enter_b", int'(state), 1);
        press(4'd4); press(4'd5); press(4'd6);
        check("b_456", int'(number2), 456);
        check("entry_456", int'(entry_value), 456);
        exp_q.push_back(14'd579);
        press(4'hA);
        check("start_pulse", int'(start_suma), 1);
        check("busy_start", int'(busy), 1);
        wait_show("op1");
        check("a_stable", int'(number1), 123);
        check("b_stable", int'(number2), 456);

        // 999 + 999 boundary, entered straight from SHOW
        press(4'd9);
        check("show_digit_state", int'(state), 0);
        check("show_digit_a", int'(number1), 9);
        press(4'd9); press(4'd9);
        press(4'hA);
        press(4'd9); press(4'd9); press(4'd9);
        check("b_999", int'(number2), 999);
        exp_q.push_back(14'd1998);
        press(4'hA);
        wait_show("op2");
        check("a_999", int'(number1), 999);

        // Digit saturation
        press(4'd2); press(4'd3); press(4'd4); press(4'd7);
        check("a_sat_234", int'(number1), 234);
        press(4'hA);
        press(4'd7); press(4'd6); press(4'd5);
        exp_q.push_back(14'd999);
        press(4'hA);
        wait_show("op3");

        // Stale valid on first WAIT cycle must not be captured
        press(4'd5);
        check("reuse_a5", int'(number1), 5);
        check("reuse_b0", int'(number2), 0);
        press(4'hA); press(4'd0);
        exp_q.push_back(14'd5);
        press(4'hA);
        wait_show("op4");

        // ENTER ignored in SHOW; CLEAR returns to ENTER_A
        press(4'hA);
        check("show_enter_ignored", int'(state), 4);
        press(4'hB);
        check("clear_state", int'(state), 0);
        check("clear_result", int'(result), 0);
        check("clear_rv", int'(result_valid), 0);

        // Empty operands: 0 + 0
        press(4'hA);
        exp_q.push_back(14'd0);
        press(4'hA);
        wait_show("op5");

        // CLEAR mid-entry
        press(4'd1); press(4'd2);
        check("a_12", int'(number1), 12);
        press(4'hB);
        check("clr_entry_state", int'(state), 0);
        check("clr_entry_a", int'(number1), 0);
        check("clr_entry_disp", int'(entry_value), 0);

        // CLEAR during WAIT aborts; the later valid (7) is ignored
        press(4'd3); press(4'hA); press(4'd4); press(4'hA);
        @(negedge clk);
        check("wait_state", int'(state), 3);
        check("wait_busy", int'(busy), 1);
        press(4'hB);
        repeat (6) @(negedge clk);
        check("abort_state", int'(state), 0);
        check("abort_result", int'(result), 0);
        check("abort_rv", int'(result_valid), 0);
        check("abort_numbers", int'({number1, number2}), 0);

        // Unused codes ignored; key during START dropped
        press(4'hC);
        check("unused_c_state", int'(state), 0);
        press(4'd1);
        press(4'hE);
        check("unused_e_a", int'(number1), 1);
        check("unused_e_state", int'(state), 0);
        press(4'hA);
        exp_q.push_back(14'd1);
        press(4'hA);
        press(4'd7);
        wait_show("op7");
        check("drop_a", int'(number1), 1);
        check("drop_b", int'(number2), 0);

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("start_count", n_start, 7);
        check("error_low", int'(error), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire

// File: doc/sum_entry_controller.md
Name: sum_entry_controller

Overview:
Sequencer between the keypad decoder and adder_submodule. Builds two decimal operands of up to 3 digits from key events and launches the adder with a one-cycle start_suma pulse. Captures sum on the adder's valid and holds it for the display path. Owns the operand registers that feed adder_submodule's number1/number2.

Parameters:
MAX_DIGITS, 3, maximum decimal digits per operand (legal 1..3, so an operand never exceeds 999).
TIMEOUT_CYCLES, 64, cycles to wait for adder valid before flagging error (used only with the optional feature).

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
key_valid  input  1  one-cycle strobe, key_code is valid.
key_code  input  4  0..9 = digit, 4'hA = ENTER, 4'hB = CLEAR, others ignored.
number1  output  12  operand A, binary, to adder.
number2  output  12  operand B, binary, to adder.
start_suma  output  1  one-cycle adder launch pulse.
sum  input  14  adder result, binary.
valid  input  1  adder result ready.
result  output  14  captured sum, held.
result_valid  output  1  high while in SHOW.
entry_value  output  12  operand currently being typed, for display.
busy  output  1  high in START or WAIT.
state  output  3  current FSM state encoding, for debug.
error  output  1  sticky timeout flag (optional feature).

Behaviour:
- Reset (reset=0, async): state=ENTER_A. number1, number2, result and entry_value=0. start_suma, result_valid, busy and error=0. digit_cnt=0.
- States: ENTER_A=0, ENTER_B=1, START=2, WAIT=3, SHOW=4.
- Digit rule (ENTER_A/ENTER_B): if digit_cnt<MAX_DIGITS, operand <= operand*10 + digit and digit_cnt++. Otherwise the digit is ignored and the operand is unchanged.
  - The operand updates on the cycle after the key_valid edge.
  - Arithmetic is 12-bit unsigned; no overflow is possible since 999 < 4096.
- entry_value mirrors number1 in ENTER_A and number2 in ENTER_B. In other states it holds its last value.
- ENTER in ENTER_A: go to ENTER_B, digit_cnt=0. An ENTER with zero digits is legal and gives operand 0.
- ENTER in ENTER_B: go to START.
- START (1 cycle): start_suma=1, busy=1. Next state is WAIT.
  - number1 and number2 are stable from START until the first key after SHOW.
- WAIT: busy=1. valid is ignored on the first WAIT cycle, so a stale valid from the previous op is never captured.
  - From the second WAIT cycle on, the first cycle with valid=1 sets result<=sum and moves to SHOW.
- SHOW: result_valid=1, result held.
  - A digit key clears number1, number2 and digit_cnt, loads the digit as the first digit of A, and goes to ENTER_A.
  - ENTER is ignored in SHOW.
- CLEAR (any state, including WAIT): next cycle state=ENTER_A. number1, number2, entry_value, result, digit_cnt and result_valid=0. error is unchanged.
  - A CLEAR in WAIT aborts the operation; a later valid is ignored.
- Key events in START/WAIT other than CLEAR are dropped.
- key_valid for unused codes (4'hC..4'hF) has no effect in any state.
- start_suma never asserts twice per operation and never asserts outside START.

Optional Feature:
Macro SUM_CTRL_TIMEOUT_EN.
- Defined: a counter runs in WAIT. If TIMEOUT_CYCLES elapse without a captured valid, set error=1 (sticky until reset), set result=0, and go to SHOW.
- Not defined: WAIT waits indefinitely, error is tied to 0, and the counter is not built.

Test Plan:
- Reset: hold reset=0 → all outputs 0, state=0. Release, then keys 1,2,3,ENTER,4,5,6,ENTER → number1=123, number2=456, one start_suma pulse; adder returns 579 → result=579, result_valid=1.
- Boundary: 9,9,9,ENTER,9,9,9,ENTER → number1=999, number2=999; result=1998, which fits 14 bits.
- Digit saturation: 2,3,4,7,ENTER → number1=234, with the 7 ignored; then 7,6,5,ENTER → result=999.
- Stale valid and reuse: in SHOW, press 5 → ENTER_A with number1=5. Then ENTER,0,ENTER, with adder valid still high from the prior op on the first WAIT cycle → that valid is not captured; the fresh valid gives result=5.
- Empty operand and CLEAR: ENTER,ENTER → start_suma with 0+0, result=0. Then 1,2,CLEAR → state=ENTER_A, number1=0. CLEAR during WAIT → valid is ignored and result stays 0.
- With SUM_CTRL_TIMEOUT_EN and valid held 0 → after 64 WAIT cycles error=1, result=0, state=SHOW. An async reset pulse mid-WAIT → immediate return to reset values.
